// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute sequencer for the 4-bit teaching CPU.
// Drives PC controls and one-cycle datapath strobes decoded from the instruction register.
module cpu_sequencer #(
  parameter int unsigned PC_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic [7:0]      instr,
  input  logic            zero_flag,
  input  logic            carry_flag,
  output logic            pc_inc,
  output logic            pc_load,
  output logic [PC_W-1:0] pc_target,
  output logic [1:0]      alu_op,
  output logic [3:0]      imm,
  output logic            acc_we,
  output logic            out_we,
  output logic [7:0]      ir,
  output logic [1:0]      state,
  output logic            halted,
  output logic [7:0]      retired
);

  localparam logic [1:0] StFetch   = 2'b00;
  localparam logic [1:0] StDecode  = 2'b01;
  localparam logic [1:0] StExecute = 2'b10;
  localparam logic [1:0] StHalted  = 2'b11;

  localparam logic [3:0] OpNop = 4'h0;
  localparam logic [3:0] OpLdi = 4'h1;
  localparam logic [3:0] OpAdd = 4'h2;
  localparam logic [3:0] OpSub = 4'h3;
  localparam logic [3:0] OpJmp = 4'h4;
  localparam logic [3:0] OpJz  = 4'h5;
  localparam logic [3:0] OpJc  = 4'h6;
  localparam logic [3:0] OpOut = 4'h7;
  localparam logic [3:0] OpHlt = 4'hF;

  logic [1:0] state_q, state_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] retired_q, retired_d;
  logic [3:0] opcode;

  assign opcode = ir_q[7:4];

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    case (state_q)
      StFetch:  if (run) state_d = StDecode;
      StDecode: begin
        ir_d    = instr;
        state_d = StExecute;
      end
      StExecute: begin
        retired_d = retired_q + 8'd1;
        state_d   = (opcode == OpHlt) ? StHalted : StFetch;
      end
      default:  state_d = StHalted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      ir_q      <= 8'h00;
      retired_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  // Strobes exist only in EXECUTE; flags are sampled live there.
  always_comb begin
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    acc_we  = 1'b0;
    out_we  = 1'b0;
    alu_op  = 2'b00;
    if (state_q == StExecute) begin
      case (opcode)
        OpLdi: begin
          acc_we = 1'b1;
          pc_inc = 1'b1;
        end
        OpAdd: begin
          acc_we = 1'b1;
          alu_op = 2'b01;
          pc_inc = 1'b1;
        end
        OpSub: begin
          acc_we = 1'b1;
          alu_op = 2'b10;
          pc_inc = 1'b1;
        end
        OpOut: begin
          out_we = 1'b1;
          pc_inc = 1'b1;
        end
        OpJmp: pc_load = 1'b1;
        OpJz: begin
          pc_load = zero_flag;
          pc_inc  = ~zero_flag;
        end
        OpJc: begin
          pc_load = carry_flag;
          pc_inc  = ~carry_flag;
        end
        OpHlt: ;
        OpNop:   pc_inc = 1'b1;
        default: pc_inc = 1'b1;
      endcase
    end
  end

  assign pc_target = PC_W'(ir_q[3:0]);
  assign imm       = ir_q[3:0];
  assign ir        = ir_q;
  assign state     = state_q;
  assign halted    = (state_q == StHalted);
  assign retired   = retired_q;

endmodule
